// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit parallel-prefix adder among NUM_REQ requesters,
// with a chain lock that forwards the carry between multi-word beats of one owner.

module ppa_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] gen_s;
  logic [31:0] prop_s;
  logic [31:0] gen_n_s;
  logic [31:0] prop_n_s;
  logic [32:0] carry_s;

  // Kogge-Stone prefix tree; after five levels gen/prop span bit i down to bit 0.
  always_comb begin
    gen_s    = a & b;
    prop_s   = a ^ b;
    gen_n_s  = gen_s;
    prop_n_s = prop_s;
    for (int lvl = 0; lvl < 32'sd5; lvl++) begin
      gen_n_s  = gen_s;
      prop_n_s = prop_s;
      for (int i = (32'sd1 <<< lvl); i < 32'sd32; i++) begin
        gen_n_s[i]  = gen_s[i] | (prop_s[i] & gen_s[i - (32'sd1 <<< lvl)]);
        prop_n_s[i] = prop_s[i] & prop_s[i - (32'sd1 <<< lvl)];
      end
      gen_s  = gen_n_s;
      prop_s = prop_n_s;
    end
    carry_s = {gen_s | (prop_s & {32{cin}}), cin};
    sum     = (a ^ b) ^ carry_s[31:0];
    cout    = carry_s[32];
  end

endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_cin,
  input  logic [NUM_REQ-1:0]    req_chain,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout
);

  logic           locked_r;
  logic           locked_n_s;
  logic [IDW-1:0] owner_r;
  logic [IDW-1:0] owner_n_s;
  logic [IDW-1:0] last_grant_r;
  logic [IDW-1:0] last_grant_n_s;
  logic           carry_r;
  logic           carry_n_s;

  logic           grant_valid_s;
  logic [IDW-1:0] grant_idx_s;
  int             cand_s;
  logic           accept_s;
  logic [31:0]    add_a_s;
  logic [31:0]    add_b_s;
  logic           add_cin_s;
  logic [31:0]    add_sum_s;
  logic           add_cout_s;

  // Grant selection: the lock owner only, else the nearest requester after last_grant.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = last_grant_r;
    cand_s        = 0;
    if (locked_r) begin
      grant_idx_s   = owner_r;
      grant_valid_s = req_valid[owner_r];
    end else begin
      // Walk from farthest to nearest so the nearest valid requester is written last.
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand_s = (int'(last_grant_r) + k >= NUM_REQ) ? int'(last_grant_r) + k - NUM_REQ
                                                    : int'(last_grant_r) + k;
        if (req_valid[cand_s]) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = IDW'(cand_s);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
  end

  assign accept_s  = grant_valid_s & (~rsp_valid | rsp_ready) & ~reset;
  assign add_a_s   = req_a[{grant_idx_s, 5'd0} +: 32];
  assign add_b_s   = req_b[{grant_idx_s, 5'd0} +: 32];
  assign add_cin_s = locked_r ? carry_r : req_cin[grant_idx_s];

  ppa_32bit u_ppa (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Lock state, owner, round-robin pointer and chained carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_r     <= 1'b0;
      owner_r      <= '0;
      last_grant_r <= IDW'(NUM_REQ - 1);
      carry_r      <= 1'b0;
    end else begin
      locked_r     <= locked_n_s;
      owner_r      <= owner_n_s;
      last_grant_r <= last_grant_n_s;
      carry_r      <= carry_n_s;
    end
  end

  // Next state: a chained beat locks to its requester; a final beat ends the turn.
  always_comb begin
    locked_n_s     = locked_r;
    owner_n_s      = owner_r;
    last_grant_n_s = last_grant_r;
    carry_n_s      = carry_r;
    if (accept_s) begin
      if (req_chain[grant_idx_s]) begin
        locked_n_s = 1'b1;
        owner_n_s  = grant_idx_s;
        carry_n_s  = add_cout_s;
      end else begin
        locked_n_s     = 1'b0;
        last_grant_n_s = grant_idx_s;
      end
    end else begin
      locked_n_s = locked_r;
    end
  end

  // Ready is one-hot on the granted requester whenever the response slot can take a beat.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Response register: loads on accept, holds under backpressure, clears on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= 32'd0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else if (accept_s) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= add_sum_s;
      rsp_cout  <= add_cout_s;
      rsp_id    <= grant_idx_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter that shares one 32-bit parallel-prefix adder (`ppa_32bit`, instantiated internally) among `NUM_REQ` requesters in the RISC-V pipelined CPU, e.g. branch-target, load/store address and multiply-accumulate helpers. It returns one registered, ID-tagged response stream. A chain lock lets a requester issue multi-word (64/96-bit) additions as back-to-back beats. Between beats the carry passes through an internal register and no other requester can interleave.

## Interface
- `NUM_REQ`, default 3: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NUM_REQ)`: response ID width; derived, never overridden.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  32*NUM_REQ  operand A; requester i drives bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand B, same packing as `req_a`.
- `req_cin`  in  NUM_REQ  carry-in; ignored on chained continuation beats.
- `req_chain`  in  NUM_REQ  1 = a further beat follows from this requester.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sum`  out  32  A + B + carry, modulo 2^32.
- `rsp_cout`  out  1  carry out of bit 31.

## Operation
- **States:** UNLOCKED and LOCKED(owner). Reset enters UNLOCKED with `last_grant` = NUM_REQ-1, so requester 0 has top priority.
- **Arbitration in UNLOCKED:** grant the first requester with `req_valid`=1, searching from `last_grant`+1 upward and wrapping modulo NUM_REQ.
- **Arbitration in LOCKED:** only the owner may be granted. Other requests stall regardless of priority.
- **Ready:** `req_ready[g]` = grant[g] & (~`rsp_valid` | `rsp_ready`). All other bits are 0.
- **Accept:** a beat is accepted when `req_valid[g]` & `req_ready[g]`.
- **Adder carry-in:** in UNLOCKED the adder takes `req_cin[g]`. In LOCKED it takes `carry_q`, the registered `cout` of the owner's previous beat.
- **Accepted beat with `req_chain`=1:** next state is LOCKED(g), and `carry_q` loads the adder `cout`.
- **Accepted beat with `req_chain`=0:** next state is UNLOCKED, and `last_grant` loads g.
- **Pointer update:** `last_grant` updates only on the last beat of a chain. A whole chain counts as one round-robin turn.
- **Owner stalls while locked:** the state holds and `carry_q` holds. There is no timeout.
- **Response register:** loads on every accepted beat, capturing sum, cout and g. It holds while `rsp_valid` & ~`rsp_ready`.
- **`rsp_valid` next value:** set on accept; cleared on `rsp_ready` without a new accept; stays 1 when drain and accept happen in the same cycle.
- **Arithmetic:** unsigned 32-bit with explicit carry. Subtraction is performed by the requester (invert B, `cin`=1); the arbiter does not special-case it.

## Timing
- **Reset values:** `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `req_ready`=0 during the reset cycle, `carry_q`=0, state UNLOCKED.
- **Latency:** exactly 1 cycle from accept edge to `rsp_valid`. The adder path is combinational within the accept cycle.
- **Throughput:** 1 beat/cycle when `rsp_ready` is held at 1, including back-to-back beats from different requesters.
- **Backpressure:** with `rsp_valid`=1 and `rsp_ready`=0, all `req_ready` are 0 and the response fields are stable.
- **Reset mid-chain:** synchronous reset in LOCKED returns to UNLOCKED and drops any pending response. The owner must restart the chain.
- **Request protocol:** requesters hold valid and operands stable until accepted. The arbiter may re-evaluate its grant every cycle while a request is not accepted.

## Test plan
- **Single add:** after reset, req0 A=0x0000_0005, B=0x0000_0003, cin=0, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_sum`=0x0000_0008, `rsp_cout`=0, `rsp_id`=0.
- **Round-robin fairness:** all three requesters hold valid, no chaining, `rsp_ready`=1 → grant order 0,1,2,0,1,2, one response per cycle with matching `rsp_id`.
- **64-bit chain:** req1 sends beat 1 A=0xFFFF_FFFF, B=0x0000_0001, chain=1, then beat 2 A=0, B=0, cin=0 (ignored), chain=0, while req0/req2 hold valid throughout → responses (id1, sum 0x0, cout 1) then (id1, sum 0x1, cout 0); req0/req2 are not granted between the two beats; the next grant goes to req2.
- **Backpressure:** `rsp_ready`=0 for 3 cycles with a response pending → `rsp_*` stable, every `req_ready`=0; on `rsp_ready`=1 the same cycle both drains and accepts, and `rsp_valid` stays 1.
- **Reset mid-chain:** req2 beat 1 with chain=1 is accepted, then `reset`=1 for one cycle → `rsp_valid`=0, state UNLOCKED, `carry_q`=0; after reset, req0 is granted first.
- **Subtract / overflow:** req0 A=0x8000_0000, B=~0x0000_0001=0xFFFF_FFFE, cin=1 → `rsp_sum`=0x7FFF_FFFF, `rsp_cout`=1.
